// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and the writeback command record
package cpu_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 3;
    localparam int NREGS      = 8;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with one-hot combinational grants
module rr_arb2 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio;

    // grant the lone requester, or the favoured one under contention; nothing while in reset
    always_comb begin
        gnt[0] = !RESET && req[0] && (!req[1] || !prio);
        gnt[1] = !RESET && req[1] && (!req[0] || prio);
    end

    // hand priority to the other requester after every grant
    always_ff @(posedge CLK) begin
        if (RESET)
            prio <= 1'b0;
        else if (gnt[0])
            prio <= 1'b1;
        else if (gnt[1])
            prio <= 1'b0;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register-file write port between ALU and load unit, with a pending-write scoreboard
module reg_write_arbiter
    import cpu_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ0_VALID,
    input  logic [REG_ADDR_W-1:0] REQ0_ADDR,
    input  logic [DATA_W-1:0]     REQ0_DATA,
    output logic                  REQ0_READY,
    input  logic                  REQ1_VALID,
    input  logic [REG_ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0]     REQ1_DATA,
    output logic                  REQ1_READY,
    input  logic                  RSV_VALID,
    input  logic [REG_ADDR_W-1:0] RSV_ADDR,
    output logic                  WRITE,
    output logic [REG_ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0]     IN,
    output logic [NREGS-1:0]      BUSY,
    output logic                  WR_ERR
);

    logic [1:0]            gnt;
    logic                  any_gnt;
    logic [REG_ADDR_W-1:0] gaddr;
    logic [DATA_W-1:0]     gdata;
    logic [NREGS-1:0]      set_m;
    logic [NREGS-1:0]      clr_m;
    wr_cmd_t               cmd;

    rr_arb2 u_arb (
        .CLK   (CLK),
        .RESET (RESET),
        .req   ({REQ1_VALID, REQ0_VALID}),
        .gnt   (gnt)
    );

    assign REQ0_READY = gnt[0];
    assign REQ1_READY = gnt[1];
    assign WRITE      = cmd.valid;
    assign INADDRESS  = cmd.addr;
    assign IN         = cmd.data;

    // select the winner's payload and build the scoreboard set/clear masks
    always_comb begin
        any_gnt = |gnt;
        gaddr   = gnt[1] ? REQ1_ADDR : REQ0_ADDR;
        gdata   = gnt[1] ? REQ1_DATA : REQ0_DATA;
        clr_m   = any_gnt ? NREGS'(1) << gaddr : '0;
        set_m   = RSV_VALID ? NREGS'(1) << RSV_ADDR : '0;
    end

    // register the write command; set beats clear so a fresh reservation survives a same-edge write
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd    <= '0;
            BUSY   <= '0;
            WR_ERR <= 1'b0;
        end else begin
            cmd.valid <= any_gnt;
            if (any_gnt) begin
                cmd.addr <= gaddr;
                cmd.data <= gdata;
            end
            BUSY   <= (BUSY & ~clr_m) | set_m;
            WR_ERR <= WR_ERR | (any_gnt & ~BUSY[gaddr]);
        end
    end

endmodule
